// File: rtl/life_gen_sequencer.sv
// life_gen_sequencer: Life grid load/step/stream controller; LIFE_GEN_SEQUENCER_STABLE_DETECT_EN adds still-life detection
module life_gen_sequencer #(
  parameter int WIDTH = 16,
  parameter int HEIGHT = 16,
  parameter int GEN_W = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_load,
  input  logic [WIDTH*HEIGHT-1:0]   load_pattern,
  input  logic                      cmd_run,
  input  logic                      cmd_step,
  input  logic                      cmd_pause,
  input  logic [WIDTH*HEIGHT-1:0]   grid_states,
  output logic                      grid_reset,
  output logic [WIDTH*HEIGHT-1:0]   grid_init,
  output logic                      grid_step,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      pix_data,
  output logic                      pix_eol,
  output logic                      pix_eof,
  output logic [GEN_W-1:0]          generation,
  output logic                      running,
  output logic                      busy,
  output logic                      extinct,
  output logic                      stable
);
  localparam int N = WIDTH * HEIGHT;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, STREAM, STEP} state_t;
  state_t state, state_nx;
  logic [N-1:0] frame;
  logic [IW-1:0] idx;
  logic [CW-1:0] col;
  logic pending, last;
`ifdef LIFE_GEN_SEQUENCER_STABLE_DETECT_EN
  logic [N-1:0] prev;
  logic from_step, same;
  assign same = grid_states == prev;
`else
  assign stable = 1'b0;
`endif
  assign pix_valid = state == STREAM;
  assign pix_data = pix_valid & frame[idx];
  assign pix_eol = pix_valid && col == CW'(WIDTH - 1);
  assign pix_eof = pix_valid && idx == IW'(N - 1);
  assign last = pix_eof && pix_ready;
  assign grid_reset = state == LOAD;
  assign grid_step = state == STEP;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   state_nx = cmd_load ? LOAD : cmd_pause ? IDLE : (cmd_step || cmd_run) ? STEP : IDLE;
      LOAD:   state_nx = SETTLE;
      STEP:   state_nx = SETTLE;
      SETTLE: state_nx = STREAM;
      STREAM: state_nx = !last ? STREAM : (pending || cmd_load) ? LOAD : (running && !cmd_pause) ? STEP : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grid_init <= '0;
      generation <= '0;
      running <= 1'b0;
      extinct <= 1'b0;
      pending <= 1'b0;
      frame <= '0;
      idx <= '0;
      col <= '0;
`ifdef LIFE_GEN_SEQUENCER_STABLE_DETECT_EN
      stable <= 1'b0;
      prev <= '0;
      from_step <= 1'b0;
`endif
    end else begin
      // a load arriving mid-frame is remembered and taken at frame end
      if (cmd_load) grid_init <= load_pattern;
      if (busy && cmd_load) pending <= 1'b1;
      if (cmd_load || cmd_pause) running <= 1'b0;
      else if (state == IDLE && !cmd_step && cmd_run) running <= 1'b1;
`ifdef LIFE_GEN_SEQUENCER_STABLE_DETECT_EN
      from_step <= state == STEP;
`endif
      case (state)
        LOAD: begin
          generation <= '0;
          running <= 1'b0;
          pending <= cmd_load;
`ifdef LIFE_GEN_SEQUENCER_STABLE_DETECT_EN
          stable <= 1'b0;
`endif
        end
        STEP: generation <= generation + 1'b1;
        SETTLE: begin
          frame <= grid_states;
          extinct <= grid_states == '0;
`ifdef LIFE_GEN_SEQUENCER_STABLE_DETECT_EN
          prev <= grid_states;
          if (from_step) stable <= same;
          if (from_step && same) running <= 1'b0;
`endif
        end
        STREAM: if (pix_ready) begin
          idx <= last ? '0 : idx + 1'b1;
          col <= pix_eol ? '0 : col + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_life_gen_sequencer.sv
// tb_life_gen_sequencer: directed checks of load/step/stream/run/pause on a 4x4 torus
module tb_life_gen_sequencer;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;
  logic clock = 1'b0, reset = 1'b1;
  logic cmd_load = 1'b0, cmd_run = 1'b0, cmd_step = 1'b0, cmd_pause = 1'b0, pix_ready = 1'b1;
  logic [N-1:0] load_pattern = '0, grid = '0, grid_init;
  logic grid_reset, grid_step, pix_valid, pix_data, pix_eol, pix_eof, running, busy, extinct, stable;
  logic [15:0] generation;
  int checks = 0, failures = 0, rst_cnt = 0, step_cnt = 0;
  logic [31:0] data, eolm, eofm;
  int beats, s0, r0;
  logic stall_ok;

  always #5 clock = ~clock;

  life_gen_sequencer #(.WIDTH(W), .HEIGHT(H), .GEN_W(16)) dut (
    .clock(clock), .reset(reset), .cmd_load(cmd_load), .load_pattern(load_pattern),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_pause(cmd_pause), .grid_states(grid),
    .grid_reset(grid_reset), .grid_init(grid_init), .grid_step(grid_step),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_eol(pix_eol),
    .pix_eof(pix_eof), .generation(generation), .running(running), .busy(busy),
    .extinct(extinct), .stable(stable)
  );

  function automatic logic [N-1:0] life(input logic [N-1:0] g);
    logic [N-1:0] r;
    r = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy != 0 || dx != 0) n += int'(g[((y + dy + H) % H) * W + (x + dx + W) % W]);
        r[y * W + x] = (n == 3) || (g[y * W + x] && n == 2);
      end
    return r;
  endfunction

  // behavioural cell array: follows the load/advance strobes one cycle later
  always @(posedge clock or posedge reset)
    if (reset) grid <= '0;
    else if (grid_reset) grid <= grid_init;
    else if (grid_step) grid <= life(grid);

  always @(posedge clock) begin
    if (grid_reset) rst_cnt <= rst_cnt + 1;
    if (grid_step) step_cnt <= step_cnt + 1;
  end

  task automatic do_load(input logic [N-1:0] p);
    cmd_load = 1'b1; load_pattern = p;
    @(negedge clock); cmd_load = 1'b0;
  endtask

  task automatic do_step;
    cmd_step = 1'b1;
    @(negedge clock); cmd_step = 1'b0;
  endtask

  task automatic do_run;
    cmd_run = 1'b1;
    @(negedge clock); cmd_run = 1'b0;
  endtask

  task automatic collect(input int stall_at, input int pause_at, input int load_at, input int abort_at,
                         input logic [N-1:0] lpat);
    int cyc;
    logic done, d0;
    data = '0; eolm = '0; eofm = '0; beats = 0; stall_ok = 1'b1; done = 1'b0; cyc = 0;
    while (!done && cyc < 300) begin
      @(negedge clock); cyc++;
      cmd_pause = 1'b0; cmd_load = 1'b0;
      if (pix_valid) begin
        if (beats == abort_at) return;
        if (beats == stall_at) begin
          d0 = pix_data; pix_ready = 1'b0;
          repeat (5) begin
            @(negedge clock);
            if (pix_valid !== 1'b1 || pix_data !== d0) stall_ok = 1'b0;
          end
          pix_ready = 1'b1;
        end
        if (beats == pause_at) cmd_pause = 1'b1;
        if (beats == load_at) begin cmd_load = 1'b1; load_pattern = lpat; end
        if (beats < 32) begin data[beats] = pix_data; eolm[beats] = pix_eol; eofm[beats] = pix_eof; end
        done = pix_eof;
        beats++;
      end
    end
    checks++; if (!done) begin failures++; $display("FAIL collect_timeout beats=%0d", beats); end
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 50) begin @(negedge clock); n++; end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_timeout busy=%b", busy); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    checks++; if ({pix_valid, pix_eof, busy, running, extinct, stable, grid_reset, grid_step} !== 8'h0) begin failures++; $display("FAIL reset_flags got=%b exp=0", {pix_valid, pix_eof, busy, running, extinct, stable, grid_reset, grid_step}); end
    checks++; if (generation !== 16'h0) begin failures++; $display("FAIL reset_gen got=%0h exp=0", generation); end
    checks++; if (grid_init !== 16'h0) begin failures++; $display("FAIL reset_init got=%0h exp=0", grid_init); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if ({busy, pix_valid} !== 2'b00) begin failures++; $display("FAIL post_reset_idle got=%b exp=00", {busy, pix_valid}); end
  endtask

  task automatic test_load_step;
    r0 = rst_cnt; s0 = step_cnt;
    do_load(16'h0070);
    collect(-1, -1, -1, -1, '0);
    checks++; if (data !== 32'h0070) begin failures++; $display("FAIL load_frame got=%0h exp=0070", data); end
    checks++; if (generation !== 16'd0) begin failures++; $display("FAIL load_gen got=%0d exp=0", generation); end
    @(negedge clock);
    checks++; if ({pix_valid, busy} !== 2'b00) begin failures++; $display("FAIL valid_drop got=%b exp=00", {pix_valid, busy}); end
    do_step;
    collect(-1, -1, -1, -1, '0);
    checks++; if (data !== 32'h0222) begin failures++; $display("FAIL step_frame got=%0h exp=0222", data); end
    checks++; if (eolm !== 32'h8888) begin failures++; $display("FAIL step_eol got=%0h exp=8888", eolm); end
    checks++; if (eofm !== 32'h8000) begin failures++; $display("FAIL step_eof got=%0h exp=8000", eofm); end
    checks++; if (beats !== 16) begin failures++; $display("FAIL step_beats got=%0d exp=16", beats); end
    checks++; if (generation !== 16'd1) begin failures++; $display("FAIL step_gen got=%0d exp=1", generation); end
    checks++; if (rst_cnt - r0 !== 1 || step_cnt - s0 !== 1) begin failures++; $display("FAIL strobe_count resets=%0d steps=%0d exp=1/1", rst_cnt - r0, step_cnt - s0); end
    wait_idle;
  endtask

  task automatic test_stall;
    do_step;
    collect(6, -1, -1, -1, '0);
    checks++; if (stall_ok !== 1'b1) begin failures++; $display("FAIL stall_hold got=%b exp=1", stall_ok); end
    checks++; if (data !== 32'h0070 || beats !== 16) begin failures++; $display("FAIL stall_frame got=%0h/%0d exp=0070/16", data, beats); end
    checks++; if (eofm !== 32'h8000) begin failures++; $display("FAIL stall_eof got=%0h exp=8000", eofm); end
    checks++; if (generation !== 16'd2) begin failures++; $display("FAIL stall_gen got=%0d exp=2", generation); end
    wait_idle;
  endtask

  task automatic test_run_pause;
    do_load(16'h0070);
    collect(-1, -1, -1, -1, '0);
    wait_idle;
    s0 = step_cnt;
    do_run;
    collect(-1, -1, -1, -1, '0);
    checks++; if (data !== 32'h0222 || running !== 1'b1) begin failures++; $display("FAIL run_f1 got=%0h run=%b exp=0222/1", data, running); end
    collect(-1, -1, -1, -1, '0);
    checks++; if (data !== 32'h0070) begin failures++; $display("FAIL run_f2 got=%0h exp=0070", data); end
    collect(-1, 8, -1, -1, '0);
    checks++; if (data !== 32'h0222 || running !== 1'b0) begin failures++; $display("FAIL run_f3 got=%0h run=%b exp=0222/0", data, running); end
    checks++; if (generation !== 16'd3) begin failures++; $display("FAIL pause_gen got=%0d exp=3", generation); end
    wait_idle;
    repeat (20) @(negedge clock);
    checks++; if (step_cnt - s0 !== 3 || busy !== 1'b0) begin failures++; $display("FAIL pause_steps got=%0d busy=%b exp=3/0", step_cnt - s0, busy); end
  endtask

  task automatic test_extinct;
    do_load(16'h0000);
    collect(-1, -1, -1, -1, '0);
    checks++; if (extinct !== 1'b1 || generation !== 16'd0) begin failures++; $display("FAIL extinct_load ext=%b gen=%0d exp=1/0", extinct, generation); end
    wait_idle;
    do_step;
    collect(-1, -1, -1, -1, '0);
    checks++; if (extinct !== 1'b1 || generation !== 16'd1 || data !== 32'h0) begin failures++; $display("FAIL extinct_step ext=%b gen=%0d data=%0h exp=1/1/0", extinct, generation, data); end
    wait_idle;
  endtask

  task automatic test_load_deferred;
    do_step;
    collect(-1, -1, 4, -1, 16'h0070);
    checks++; if (generation !== 16'd2 || data !== 32'h0) begin failures++; $display("FAIL defer_frame gen=%0d data=%0h exp=2/0", generation, data); end
    collect(-1, -1, -1, -1, '0);
    checks++; if (data !== 32'h0070 || generation !== 16'd0 || extinct !== 1'b0) begin failures++; $display("FAIL defer_load data=%0h gen=%0d ext=%b exp=0070/0/0", data, generation, extinct); end
    wait_idle;
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL defer_running got=%b exp=0", running); end
  endtask

  task automatic test_reset_mid;
    do_step;
    collect(-1, -1, -1, 9, '0);
    checks++; if (beats !== 9 || eofm !== 32'h0) begin failures++; $display("FAIL abort_beats got=%0d eof=%0h exp=9/0", beats, eofm); end
    reset = 1'b1;
    #1;
    checks++; if ({pix_valid, pix_eof, pix_eol, pix_data, busy, running, extinct, stable, grid_reset, grid_step} !== 10'h0) begin failures++; $display("FAIL midreset_flags got=%b exp=0", {pix_valid, pix_eof, pix_eol, pix_data, busy, running, extinct, stable, grid_reset, grid_step}); end
    checks++; if (generation !== 16'h0 || grid_init !== 16'h0) begin failures++; $display("FAIL midreset_regs gen=%0h init=%0h exp=0/0", generation, grid_init); end
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    do_load(16'h0033);
    collect(-1, -1, -1, -1, '0);
    checks++; if (data !== 32'h0033 || generation !== 16'd0 || beats !== 16) begin failures++; $display("FAIL reload data=%0h gen=%0d beats=%0d exp=0033/0/16", data, generation, beats); end
    wait_idle;
  endtask

  task automatic test_stable;
    do_run;
    collect(-1, -1, -1, -1, '0);
    checks++; if (data !== 32'h0033 || generation !== 16'd1) begin failures++; $display("FAIL block_frame data=%0h gen=%0d exp=0033/1", data, generation); end
`ifdef LIFE_GEN_SEQUENCER_STABLE_DETECT_EN
    wait_idle;
    checks++; if (stable !== 1'b1 || running !== 1'b0 || generation !== 16'd1) begin failures++; $display("FAIL stable_stop st=%b run=%b gen=%0d exp=1/0/1", stable, running, generation); end
`else
    checks++; if (stable !== 1'b0 || running !== 1'b1) begin failures++; $display("FAIL nostable_run st=%b run=%b exp=0/1", stable, running); end
    collect(-1, 3, -1, -1, '0);
    wait_idle;
    checks++; if (generation !== 16'd2 || stable !== 1'b0) begin failures++; $display("FAIL nostable_gen gen=%0d st=%b exp=2/0", generation, stable); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_load_step;
    test_stall;
    test_run_pause;
    test_extinct;
    test_load_deferred;
    test_reset_mid;
    test_stable;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/life_gen_sequencer.md
Name: life_gen_sequencer

Overview:
- Controller for the toroidal Life cell array: loads an initial pattern, issues generation-advance strobes, and streams each generation out as a row-major pixel stream for the console/display path.
- Sits between host command inputs and the cell grid.
- Provides run, pause and single-step control, a generation counter, and extinction detection.

Parameters:
WIDTH, 16, grid columns (>=2)
HEIGHT, 16, grid rows (>=2)
GEN_W, 16, generation counter width

Ports:
clock  in  1  single system clock
reset  in  1  asynchronous, active-high reset
cmd_load  in  1  pulse: load load_pattern into grid
load_pattern  in  WIDTH*HEIGHT  pattern; bit r*WIDTH+c = cell (r,c)
cmd_run  in  1  pulse: enter continuous run
cmd_step  in  1  pulse: advance exactly one generation
cmd_pause  in  1  pulse: leave run mode after current frame
grid_states  in  WIDTH*HEIGHT  current cell states from array
grid_reset  out  1  array load strobe
grid_init  out  WIDTH*HEIGHT  array load value
grid_step  out  1  array advance strobe, one cycle per generation
pix_valid  out  1  pixel stream valid
pix_ready  in  1  pixel stream ready
pix_data  out  1  cell alive
pix_eol  out  1  last column of row
pix_eof  out  1  last pixel of frame
generation  out  GEN_W  generations since last load
running  out  1  run mode active
busy  out  1  state != IDLE
extinct  out  1  last streamed frame was all-dead
stable  out  1  last step produced an identical grid (feature only)

Behaviour:
- Reset (async): state=IDLE; all outputs 0, including grid_init, generation, flags and pixel counters. A reset mid-frame aborts the stream with no eof.
- Grid contract: grid_states reflects a grid_reset or grid_step strobe on the cycle after the strobe. The sequencer never samples grid_states in the strobe cycle.
- States: IDLE, LOAD, SETTLE, STREAM, STEP.
- IDLE:
  - cmd_load -> LOAD.
  - cmd_step -> STEP.
  - cmd_run -> running=1 -> STEP.
  - Commands arriving while busy are ignored, except cmd_pause and cmd_load.
- LOAD (1 cycle):
  - grid_reset=1; grid_init=load_pattern captured at cmd_load.
  - generation<=0; running<=0.
  - -> SETTLE.
- STEP (1 cycle):
  - grid_step=1; generation<=generation+1, wrapping modulo 2^GEN_W with no saturation.
  - -> SETTLE.
- SETTLE (1 cycle):
  - Snapshot grid_states into a frame register; extinct<=(snapshot==0).
  - -> STREAM.
  - The stream shows the snapshot, not the live grid.
- STREAM:
  - Row-major order, row 0 column 0 first. pix_data=snapshot[row*WIDTH+col].
  - pix_eol when col==WIDTH-1; pix_eof when also row==HEIGHT-1.
  - Advances only on pix_valid&&pix_ready. pix_valid and pix_data stay stable while stalled.
  - After the eof handshake, pix_valid drops the next cycle. Then: running -> STEP, else -> IDLE.
  - Frame length is exactly WIDTH*HEIGHT beats.
- cmd_pause: clears running immediately. The current frame still completes; the FSM then returns to IDLE.
- cmd_load while busy: deferred. Latched as pending and taken at frame end instead of STEP/IDLE; running is cleared.
- Same-cycle priority: cmd_load > cmd_pause > cmd_step > cmd_run.
- Minimum generation period in run mode with pix_ready=1: WIDTH*HEIGHT+2 cycles (STEP, SETTLE, N beats).
- Extinct grid in run mode: keeps stepping; extinct stays 1.

Optional Feature:
- Macro: LIFE_GEN_SEQUENCER_STABLE_DETECT_EN.
- Defined:
  - Keeps the previous frame's snapshot. In SETTLE after a STEP, stable<=(new==previous).
  - If stable while running: running<=0, and the FSM goes to IDLE after the frame. This covers still lifes and extinction; oscillators are not detected.
  - stable clears on LOAD.
- Undefined: no previous-frame register; stable tied 0; run continues indefinitely.

Test Plan:
- Load a single blinker (cells (1,0),(1,1),(1,2)) with WIDTH=HEIGHT=4, then cmd_step with pix_ready=1 -> one grid_reset pulse, one grid_step pulse, generation=1, a 16-beat stream with live pixels at (0,1),(1,1),(2,1), eol on beats 3/7/11/15, eof on beat 15.
- Hold pix_ready=0 for 5 cycles at beat 6 -> pix_valid/pix_data unchanged, no beat lost, eof still on beat 15.
- cmd_run on a blinker, cmd_pause asserted mid-frame 3 -> frame 3 completes, no further grid_step, generation=3, running=0, busy=0.
- cmd_load with an all-zero pattern -> generation=0, extinct=1 after SETTLE; cmd_step keeps extinct=1, generation=1.
- Assert reset mid-stream (beat 9) -> all outputs 0 the same cycle, no eof; a subsequent cmd_load works normally.
- With LIFE_GEN_SEQUENCER_STABLE_DETECT_EN, run on a 2x2 block -> stable=1 after first step frame, running=0, IDLE with generation=1. Without the macro, stable=0 and stepping continues.
